ipml_fifo_wr_arbiter: RTL
=========================

// Module: ipml_fifo_wr_arbiter
// PURPOSE
//  Round-robin, burst-locking arbiter that shares one prefetch FIFO write port between N_REQ producer streams.
//  Sits between the producers (e.g. ADC capture channels) and the FIFO write side (wr_data/wr_en/wr_vld).
//  A grant is held for one packet (until last) or MAX_BURST beats, whichever comes first.
// PARAMETERS
//  N_REQ      4   number of requesters, 2..8
//  DW         32  data width, equal to FIFO c_WR_DATA_WIDTH
//  MAX_BURST  16  max accepted beats per grant, 1..256
// PORTS
//  clk           in   1         single clock; FIFO wr_clk is driven from the same net
//  rst_n         in   1         asynchronous active-low reset
//  req_valid     in   N_REQ     per-requester data valid
//  req_last      in   N_REQ     per-requester last beat of packet
//  req_data      in   N_REQ*DW  requester i occupies bits [i*DW +: DW]
//  req_ready     out  N_REQ     beat accepted when req_valid[i] & req_ready[i]
//  fifo_wr_data  out  DW        to FIFO wr_data
//  fifo_wr_en    out  1         to FIFO wr_en
//  fifo_wr_vld   in   1         FIFO not full (FIFO wr_vld)
//  grant         out  N_REQ     one-hot current owner, 0 when idle
//  busy          out  1         arbiter in GRANT state
// BEHAVIOUR
//  Reset: state=IDLE, grant=0, busy=0, rr_ptr=0, beat_cnt=0; req_ready=0, fifo_wr_en=0, fifo_wr_data=0.
//  IDLE: if any req_valid, select the first set bit searching upward from rr_ptr with wrap (rr_ptr has top priority).
//    Register grant, enter GRANT. Arbitration costs one bubble cycle; no data moves in IDLE.
//  GRANT (owner g): combinational pass-through. fifo_wr_data=req_data[g]; fifo_wr_en=req_valid[g];
//    req_ready[g]=fifo_wr_vld; every other req_ready=0. beat = req_valid[g] & fifo_wr_vld.
//  beat_cnt (width clog2(MAX_BURST+1)) increments on each beat and clears on entering GRANT.
//  Release to IDLE next cycle, with rr_ptr=(g+1) mod N_REQ and grant=0, when:
//    (a) beat & req_last[g]; (b) beat and beat_cnt==MAX_BURST-1; (c) req_valid[g]==0 (producer gap).
//  FIFO full (fifo_wr_vld=0): grant held, no beat, beat_cnt frozen, no release unless (c).
//  (a) and (b) in the same beat: a single release.
//  A lone requester is re-granted after one IDLE cycle, giving at most MAX_BURST beats per MAX_BURST+1 cycles.
//  fifo_wr_en may be high while fifo_wr_vld=0; the FIFO gates it internally. The arbiter never counts such a cycle.
//  Requests from non-owners are ignored until the next IDLE. No starvation: each waiting requester is served within N_REQ-1 grants.
//  Reset asserted mid-burst: immediate return to the reset state; any partial packet in the FIFO is the producer's concern.
// CONFIGURATION
//  `define IPML_ARB_STATS_EN compiled in: extra ports stat_clr (in, 1) and stat_beats (out, N_REQ*16).
//    stat_beats holds per-requester 16-bit saturating counts of accepted beats, reset to 0.
//    stat_clr clears all counts synchronously and takes priority over a same-cycle beat.
//  Not defined: the ports still exist; stat_beats is tied to 0, stat_clr is ignored, and no counter flops are built.
// STRUCTURE
//  Package ipml_fifo_arb_pkg: state encoding localparams (ST_IDLE, ST_GRANT), STAT_W=16, clog2 function.
//  Sub-module ipml_rr_pick: combinational N_REQ round-robin picker; inputs req and ptr, output one-hot gnt and index.
//  Top level: FSM, beat counter, output mux, optional stats.
// TESTING
//  1 Reset with req_valid=4'b1111 -> all outputs 0; 1 cycle after release grant=4'b0001, rr_ptr order 0,1,2,3,0.
//  2 Req0 sends 5 beats, last on beat 5, FIFO never full -> 5 consecutive fifo_wr_en beats, then IDLE, then grant to next requester.
//  3 MAX_BURST=16, req1 streams 40 beats with no last -> grants of 16, 16 and 8 beats, each separated by one IDLE cycle.
//  4 fifo_wr_vld held low for 3 cycles mid-burst -> req_ready=0, beat_cnt frozen, grant held, no beat lost or duplicated.
//  5 Owner drops req_valid after 2 beats while req2 waits -> release, then grant=4'b0100 two cycles after the drop.
//  6 IPML_ARB_STATS_EN: 70000 beats on req3 -> stat_beats[63:48]=16'hFFFF; pulse stat_clr -> 0 next cycle.

Source files
------------

// File: rtl/ipml_fifo_arb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ipml_fifo_arb_pkg -- shared FSM encoding, stats width and clog2 helper for the FIFO write arbiter
// Rev 1.0
package ipml_fifo_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  localparam int STAT_W = 16;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ipml_rr_pick.sv
`timescale 1ns/1ps
`default_nettype none
// ipml_rr_pick -- combinational round-robin picker: first set request at or above i_ptr, with wrap
// Rev 1.0
module ipml_rr_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [PTR_W-1:0] o_idx
);

  // Walk from the farthest position back to i_ptr so the nearest request wins last.
  always_comb begin
    logic [PTR_W-1:0] w_pos;
    o_gnt = '0;
    o_idx = '0;
    w_pos = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_pos = PTR_W'((int'(i_ptr) + k) % N_REQ);
      if (i_req[w_pos]) begin
        o_gnt        = '0;
        o_gnt[w_pos] = 1'b1;
        o_idx        = w_pos;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ipml_fifo_wr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ipml_fifo_wr_arbiter -- round-robin, burst-locking arbiter sharing one FIFO write port among N_REQ producers.
// Define IPML_ARB_STATS_EN to build per-requester saturating beat counters on stat_beats.  Rev 1.0
module ipml_fifo_wr_arbiter
  import ipml_fifo_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DW        = 32,
  parameter int MAX_BURST = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_last,
  input  logic [N_REQ*DW-1:0]     req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic [DW-1:0]           fifo_wr_data,
  output logic                    fifo_wr_en,
  input  logic                    fifo_wr_vld,
  output logic [N_REQ-1:0]        grant,
  output logic                    busy,
  input  logic                    stat_clr,
  output logic [N_REQ*STAT_W-1:0] stat_beats
);

  localparam int c_PTR_W = clog2(N_REQ);
  localparam int c_CNT_W = clog2(MAX_BURST + 1);
  localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(MAX_BURST - 1);
  localparam logic [c_PTR_W-1:0] c_LAST_IDX = c_PTR_W'(N_REQ - 1);

  arb_state_t           r_state;
  logic [N_REQ-1:0]     r_grant;
  logic [c_PTR_W-1:0]   r_owner;
  logic [c_PTR_W-1:0]   r_rr_ptr;
  logic [c_CNT_W-1:0]   r_beat_cnt;

  logic [N_REQ-1:0]     w_pick_gnt;
  logic [c_PTR_W-1:0]   w_pick_idx;
  logic [DW-1:0]        w_lane [N_REQ];
  logic                 w_active;
  logic                 w_own_valid;
  logic                 w_own_last;
  logic                 w_beat;
  logic                 w_release;

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    assign w_lane[i] = req_data[i*DW +: DW];
  end

  ipml_rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (c_PTR_W)
  ) u_pick (
    .i_req (req_valid),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx)
  );

  assign w_active    = (r_state == ST_GRANT);
  assign w_own_valid = req_valid[r_owner];
  assign w_own_last  = req_last[r_owner];
  assign w_beat      = w_active & w_own_valid & fifo_wr_vld;
  // A producer gap releases even while the FIFO is full; last/burst limit need an accepted beat.
  assign w_release   = w_active & (~w_own_valid |
                                   (w_beat & (w_own_last | (r_beat_cnt == c_LAST_CNT))));

  assign fifo_wr_data = w_active ? w_lane[r_owner] : '0;
  assign fifo_wr_en   = w_active & w_own_valid;
  assign req_ready    = (w_active & fifo_wr_vld) ? r_grant : '0;
  assign grant        = r_grant;
  assign busy         = w_active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|req_valid) begin
            r_state    <= ST_GRANT;
            r_grant    <= w_pick_gnt;
            r_owner    <= w_pick_idx;
            r_beat_cnt <= '0;
          end
        end
        ST_GRANT: begin
          if (w_beat) r_beat_cnt <= r_beat_cnt + 1'b1;
          if (w_release) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= (r_owner == c_LAST_IDX) ? '0 : r_owner + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef IPML_ARB_STATS_EN
  for (genvar i = 0; i < N_REQ; i++) begin : g_stat
    logic [STAT_W-1:0] r_stat;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                        r_stat <= '0;
      else if (stat_clr)                                 r_stat <= '0;
      else if (w_beat && r_grant[i] && (r_stat != '1))   r_stat <= r_stat + 1'b1;
    end
    assign stat_beats[i*STAT_W +: STAT_W] = r_stat;
  end
`else
  logic w_unused_stat_clr;
  assign w_unused_stat_clr = stat_clr;
  assign stat_beats        = '0;
`endif

endmodule
`default_nettype wire
